// File: rtl/sdp_ram_streamer.sv
// Streams `count` consecutive words out of a simple dual-port RAM's registered read port
// as an AXI-Stream. A 4-entry skid FIFO with credit-based read issue absorbs backpressure.
module sdp_ram_streamer #(
    parameter int DW = 512,
    parameter int DD = 16384,
    parameter int AW = $clog2(DD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] axis_tdata,
    output logic          axis_tvalid,
    output logic          axis_tlast,
    input  logic          axis_tready
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DD - 1);
    localparam logic [AW:0]   ONE_CNT   = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   issue_cnt_q, issue_cnt_d;
    logic [AW:0]   beat_cnt_q, beat_cnt_d;
    logic          inflight_q;
    logic [DW-1:0] fifo_q [4];
    logic [1:0]    wr_q, rd_q;
    logic [2:0]    fifo_cnt_q, fifo_cnt_d;
    logic          issue, push, pop;

    assign ram_addr    = ptr_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == FINISH);
    assign axis_tvalid = (fifo_cnt_q != 3'd0);
    assign axis_tdata  = fifo_q[rd_q];
    assign axis_tlast  = axis_tvalid && (beat_cnt_q == ONE_CNT);

    // Credit uses registered occupancy only, so a word being popped this cycle frees no slot yet.
    assign issue = (state_q == RUN) && (issue_cnt_q != '0) &&
                   ((fifo_cnt_q + {2'b00, inflight_q}) < 3'd4);
    assign push  = inflight_q;
    assign pop   = axis_tvalid && axis_tready;
    assign fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d     = RUN;
                        ptr_d       = start_addr;
                        issue_cnt_d = count;
                        beat_cnt_d  = count;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    ptr_d       = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AW'(1);
                    issue_cnt_d = issue_cnt_q - ONE_CNT;
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q - ONE_CNT;
                    if (beat_cnt_q == ONE_CNT) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= issue;
            fifo_cnt_q  <= fifo_cnt_d;
            if (push) begin
                fifo_q[wr_q] <= ram_dout;
                wr_q         <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdp_ram_streamer.sv
// Directed bench for sdp_ram_streamer with a small registered-read RAM model (DD=16).
module tb_sdp_ram_streamer;

    localparam int DW = 32;
    localparam int DD = 16;
    localparam int AW = $clog2(DD);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic          busy, done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, tready;

    logic [DW-1:0] ram [DD];

    int n_chk  = 0;
    int n_pass = 0;

    sdp_ram_streamer #(.DW(DW), .DD(DD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .axis_tdata (tdata),
        .axis_tvalid(tvalid),
        .axis_tlast (tlast),
        .axis_tready(tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= ram[ram_addr];

    function automatic logic [DW-1:0] word(input int i);
        return 32'hC0DE_0000 + DW'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // mode 0: tready=1; mode 1: tready pattern 1,0,0,1,0,1 repeating; mode 2: tready=0 for 20 cycles.
    task automatic run_xfer(input int addr, input int cnt, input int mode, input int restart_cyc,
                            output int beats, output int done_cyc);
        int            cyc;
        logic          stalled;
        logic [DW-1:0] held;
        logic [5:0]    pat;
        pat      = 6'b101001;
        beats    = 0;
        done_cyc = -1;
        stalled  = 1'b0;
        held     = '0;
        @(negedge clk);
        start      = 1'b1;
        start_addr = addr[AW-1:0];
        count      = cnt[AW:0];
        tready     = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 200 && done_cyc < 0) begin
            case (mode)
                0:       tready = 1'b1;
                1:       tready = pat[(cyc - 1) % 6];
                default: tready = (cyc > 20);
            endcase
            start = (cyc == restart_cyc);
            #1;
            if (stalled) chk("stall_hold", tdata, held);
            if (tvalid && tready) begin
                chk("data", tdata, word((addr + beats) % DD));
                chk("tlast", tlast, (beats == cnt - 1));
                if (mode == 0) chk("beat_cyc", cyc, 3 + beats);
                beats++;
            end
            stalled = tvalid && !tready;
            held    = tdata;
            if (mode == 2 && cyc == 20) chk("readahead", ram_addr, (addr + 4) % DD);
            if (done) begin
                done_cyc = cyc;
                chk("busy_finish", busy, 0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) chk("timeout", 0, 1);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", tvalid, 0);
    endtask

    initial begin
        int beats, dcyc, nb;
        for (int i = 0; i < DD; i++) ram[i] = word(i);
        reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_tdata", tdata, 0);
        reset = 1'b0;

        run_xfer(10, 8, 0, 0, beats, dcyc);
        chk("basic_beats", beats, 8);
        chk("basic_done", dcyc, 11);

        run_xfer(14, 4, 0, 0, beats, dcyc);
        chk("wrap_beats", beats, 4);
        chk("wrap_done", dcyc, 7);

        run_xfer(3, 6, 1, 0, beats, dcyc);
        chk("bp_beats", beats, 6);

        run_xfer(9, 6, 2, 0, beats, dcyc);
        chk("stall_beats", beats, 6);

        run_xfer(7, 0, 0, 0, beats, dcyc);
        chk("zero_beats", beats, 0);
        chk("zero_done", dcyc, 1);

        run_xfer(2, 5, 0, 2, beats, dcyc);
        chk("restart_beats", beats, 5);
        chk("restart_done", dcyc, 8);

        // Abort a count=10 transfer right after its third beat.
        @(negedge clk);
        start = 1'b1; start_addr = 4'd3; count = 5'd10; tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int c = 0; c < 40 && nb < 3; c++) begin
            #1;
            if (tvalid && tready) nb++;
            @(negedge clk);
        end
        chk("abort_pre", nb, 3);
        reset = 1'b1;
        #1;
        chk("abort_valid", tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        nb = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) reset = 1'b0;
            #1;
            if (done || tvalid || busy) nb++;
        end
        chk("abort_quiet", nb, 0);

        run_xfer(0, 2, 0, 0, beats, dcyc);
        chk("post_rst_beats", beats, 2);
        chk("post_rst_done", dcyc, 5);

        run_xfer(5, 16, 0, 0, beats, dcyc);
        chk("full_beats", beats, 16);
        chk("full_done", dcyc, 19);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
